// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: LED output registers, debounced switch inputs
// and a free-running 32-bit timer with compare interrupt in a 64-byte window.
module mmio_io_hub #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC00,
  parameter int          N_LED_CH        = 2,
  parameter int          N_SW_CH         = 2,
  parameter int          LED_W           = 16,
  parameter int          SW_W            = 16,
  parameter int          DEBOUNCE_CYCLES = 100000
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      io_rd,
  input  logic                      io_wr,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      hit,
  input  logic [N_SW_CH*SW_W-1:0]   switches,
  output logic [N_LED_CH*LED_W-1:0] leds,
  output logic                      irq
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] OFF_SW0    = 4'h4;
  localparam logic [3:0] OFF_TCOUNT = 4'h8;
  localparam logic [3:0] OFF_TCMP   = 4'h9;
  localparam logic [3:0] OFF_STATUS = 4'hA;

  logic [3:0] off;
  logic       wr_en;
  logic       rd_en;
  logic       unused_addr_bits;

  logic [N_LED_CH-1:0][LED_W-1:0] led_q, led_d;

  logic [N_SW_CH-1:0][SW_W-1:0] sync1_q, sync2_q;
  logic [N_SW_CH-1:0][SW_W-1:0] stable_q, stable_d;
  logic [N_SW_CH-1:0][CW-1:0]   cnt_q, cnt_d;

  logic [31:0] tcount_q, tcount_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        flag_q, flag_d;
  logic        irqen_q, irqen_d;

  logic [31:0] rd_val;
  logic [31:0] rdata_q, rdata_d;

  assign off   = addr[5:2];
  assign hit   = (addr[31:6] == BASE_ADDR[31:6]);
  assign wr_en = io_wr & hit;
  assign rd_en = io_rd & hit;

  assign unused_addr_bits = ^addr[1:0];

  assign leds  = led_q;
  assign rdata = rdata_q;
  assign irq   = flag_q & irqen_q;

  always_comb begin
    led_d = led_q;
    for (int i = 0; i < N_LED_CH; i++) begin
      if (wr_en && off == 4'(i)) begin
        led_d[i] = wdata[LED_W-1:0];
      end
    end
  end

  // Change is accepted once sync has differed from stable for
  // DEBOUNCE_CYCLES edges; the count is not restarted if sync moves again.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int j = 0; j < N_SW_CH; j++) begin
      if (sync2_q[j] != stable_q[j]) begin
        if (cnt_q[j] == CNT_MAX) begin
          stable_d[j] = sync2_q[j];
        end else begin
          cnt_d[j] = cnt_q[j] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    tcount_d = tcount_q + 32'd1;
    tcmp_d   = tcmp_q;
    flag_d   = flag_q;
    irqen_d  = irqen_q;
    if (wr_en && off == OFF_TCOUNT) begin
      tcount_d = wdata;
    end
    if (wr_en && off == OFF_TCMP) begin
      tcmp_d = wdata;
    end
    if (wr_en && off == OFF_STATUS) begin
      if (wdata[0]) begin
        flag_d = 1'b0;
      end
      irqen_d = wdata[1];
    end
    // A match on the same edge as a clear keeps the flag set.
    if (tcount_q == tcmp_q) begin
      flag_d = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_LED_CH; i++) begin
      if (off == 4'(i)) begin
        rd_val = 32'(led_q[i]);
      end
    end
    for (int j = 0; j < N_SW_CH; j++) begin
      if (off == OFF_SW0 + 4'(j)) begin
        rd_val = 32'(stable_q[j]);
      end
    end
    if (off == OFF_TCOUNT) begin
      rd_val = tcount_q;
    end
    if (off == OFF_TCMP) begin
      rd_val = tcmp_q;
    end
    if (off == OFF_STATUS) begin
      rd_val = {30'd0, irqen_q, flag_q};
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_val;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      led_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      tcount_q <= '0;
      tcmp_q   <= 32'hFFFF_FFFF;
      flag_q   <= 1'b0;
      irqen_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      led_q    <= led_d;
      sync1_q  <= switches;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      flag_q   <= flag_d;
      irqen_q  <= irqen_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Randomised and directed bench for mmio_io_hub with a read scoreboard
// fed by a behavioural register model.
module tb_mmio_io_hub;

  localparam logic [31:0] BASE = 32'hFFFF_FC00;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic [31:0] switches = '0;
  logic [31:0] leds;
  logic        irq;

  mmio_io_hub #(
    .BASE_ADDR(BASE),
    .N_LED_CH(2),
    .N_SW_CH(2),
    .LED_W(16),
    .SW_W(16),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clk),
    .rst(rst),
    .io_rd(io_rd),
    .io_wr(io_wr),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .hit(hit),
    .switches(switches),
    .leds(leds),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // edges since reset release
  logic [31:0] cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= '0;
    else cyc <= cyc + 32'd1;

  logic [15:0] led_m[2];
  logic [15:0] sw_m[2];
  logic [31:0] t_v, t_l, tcmp_m;
  logic        en_m, flag_m;

  task automatic model_reset();
    led_m[0] = '0; led_m[1] = '0;
    sw_m[0] = '0;  sw_m[1] = '0;
    t_v = '0; t_l = '0;
    tcmp_m = 32'hFFFF_FFFF;
    en_m = 1'b0; flag_m = 1'b0;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] off);
    logic [31:0] v;
    v = '0;
    if (off < 4'd2) v = {16'd0, led_m[off[0]]};
    else if (off == 4'd4 || off == 4'd5) v = {16'd0, sw_m[off[0]]};
    else if (off == 4'd8) v = t_v + (cyc - t_l);
    else if (off == 4'd9) v = tcmp_m;
    else if (off == 4'd10) v = {30'd0, en_m, flag_m};
    return v;
  endfunction

  // Monitor: every hit read produces rdata one edge later.
  logic rd_pend = 1'b0;
  always @(posedge clk)
    rd_pend <= io_rd && (addr[31:6] == BASE[31:6]) && !rst;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %h expected none", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic exp_hit);
    io_rd = rd; io_wr = wr; addr = a; wdata = d;
    #1;
    check("hit", {31'd0, hit}, {31'd0, exp_hit});
    @(negedge clk);
    io_rd = 1'b0; io_wr = 1'b0;
  endtask

  function automatic logic [31:0] win(input logic [3:0] off);
    return BASE | {26'd0, off, 2'b00};
  endfunction

  task automatic model_write(input logic [3:0] off, input logic [31:0] d);
    if (off < 4'd2) led_m[off[0]] = d[15:0];
    else if (off == 4'd8) begin t_v = d; t_l = cyc + 32'd1; end
    else if (off == 4'd9) tcmp_m = d;
    else if (off == 4'd10) en_m = d[1];
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] d);
    model_write(off, d);
    bus(1'b0, 1'b1, win(off), d, 1'b1);
  endtask

  task automatic rd_reg(input logic [3:0] off);
    exp_q.push_back(model_read(off));
    bus(1'b1, 1'b0, win(off), 32'd0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0]  off;
    logic        inwin;
    logic [31:0] a, d, r;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      check("rst_leds", leds, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
    end
    rst = 1'b0;
    rd_reg(4'h0);
    rd_reg(4'h1);
    rd_reg(4'h8);
    rd_reg(4'h9);
    rd_reg(4'hA);

    wr_reg(4'h1, 32'h1234_ABCD);
    check("led1_write", {16'd0, leds[31:16]}, 32'h0000_ABCD);
    rd_reg(4'h1);
    wr_reg(4'h3, 32'h5555_5555);
    check("led_unmapped", leds, {led_m[1], led_m[0]});

    for (int i = 0; i < 40; i++) begin
      check("leds_rand", leds, {led_m[1], led_m[0]});
      off = 4'($urandom_range(0, 15));
      inwin = ($urandom_range(0, 3) != 0);
      a = inwin ? win(off) : (32'h0001_0000 | {26'd0, off, 2'b00});
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (inwin) exp_q.push_back(model_read(off));
        bus(1'b1, 1'b0, a, 32'd0, inwin);
      end else begin
        if (off >= 4'd8 && off <= 4'd10) begin
          off = 4'd0;
          a = inwin ? win(off) : 32'h0001_0000;
        end
        if (inwin) model_write(off, d);
        bus(1'b0, 1'b1, a, d, inwin);
      end
    end

    // 3-cycle glitch must be rejected
    switches[15:0] = 16'h00F0;
    idle(3);
    switches[15:0] = 16'h0000;
    idle(8);
    rd_reg(4'h4);

    r = 32'($urandom_range(1, 16'hFFFF));
    switches = {r[15:0], 16'h00F0};
    idle(5);
    rd_reg(4'h4);
    sw_m[0] = 16'h00F0;
    sw_m[1] = r[15:0];
    rd_reg(4'h4);
    rd_reg(4'h5);

    wr_reg(4'h9, 32'd20);
    wr_reg(4'hA, 32'd3);
    wr_reg(4'h8, 32'd10);
    idle(10);
    check("irq_before_match", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_on_match", {31'd0, irq}, 32'd1);
    wr_reg(4'hA, 32'd3);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    wr_reg(4'h9, 32'd500);
    wr_reg(4'h8, 32'd490);
    idle(10);
    check("irq_pre_setwins", {31'd0, irq}, 32'd0);
    wr_reg(4'hA, 32'd3);
    check("irq_set_wins", {31'd0, irq}, 32'd1);

    wr_reg(4'h8, 32'hFFFF_FFFE);
    rd_reg(4'h8);
    rd_reg(4'h8);
    rd_reg(4'h8);

    wr_reg(4'h0, 32'd5);
    exp_q.push_back(model_read(4'h0));
    model_write(4'h0, 32'd9);
    bus(1'b1, 1'b1, win(4'h0), 32'd9, 1'b1);
    check("rdwr_led0", {16'd0, leds[15:0]}, 32'd9);

    io_wr = 1'b1;
    addr = win(4'h1);
    wdata = 32'h0000_BEEF;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_leds", leds, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("rst_no_write", leds, 32'd0);
    io_wr = 1'b0;
    rst = 1'b0;
    model_reset();
    rd_reg(4'h1);
    rd_reg(4'h8);
    rd_reg(4'h9);

    idle(2);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
